// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t       : divider control states
//   DEFAULT_WIDTH : default operand/result width
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_subtractor.sv
// Combinational carry-lookahead subtractor: diff = a - b = a + ~b + 1.
// Ports:
//   a, b      : N-bit unsigned operands
//   diff      : N-bit difference (modulo 2^N)
//   no_borrow : carry out of the top bit; 1 when a >= b
module cla_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    // Generate/propagate terms are taken against the inverted subtrahend.
    assign p = a ^ ~b;
    assign g = a & ~b;

    // NOTE: a combinational block assigns every output on every path before
    // any conditional logic, so no latch can be inferred.
    always_comb begin
        c[0] = 1'b1;  // the "+1" of the two's-complement negation
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff      = p ^ c[N-1:0];
    assign no_borrow = c[N];

endmodule

// File: rtl/seq_cla_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is produced per RUN cycle using a single trial
// subtraction through a WIDTH+1 bit carry-lookahead subtractor.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   start               : request, accepted only in IDLE or DONE
//   dividend, divisor   : operands, captured on an accepted start
//   busy                : high while iterating
//   done                : one-cycle pulse, results valid in that cycle
//   quotient, remainder : results, held until the next completion
//   div_by_zero         : set with done when the divisor was zero
module seq_cla_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_iter;

    logic [WIDTH-1:0] q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d;        // captured divisor
    logic [WIDTH:0]   r;        // partial remainder, one guard bit
    logic [CW-1:0]    cnt;      // iterations completed

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // The guard bit of r only ever holds a restored value < divisor, so it
    // is always 0 and is never shifted onward.
    logic             unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    // ---------------- datapath ----------------
    assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};

    cla_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a         (r_shift),
        .b         ({1'b0, d}),
        .diff      (t),
        .no_borrow (no_borrow)
    );

    // Keep the difference only when it did not go negative.
    assign r_next = no_borrow ? t : r_shift;
    assign q_next = {q[WIDTH-2:0], no_borrow};

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : RUN;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == LAST_ITER) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here, including the working operands, is
        // reset so no partial result from an aborted division survives.
        if (rst) begin
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            q   <= q_next;
            r   <= r_next;
            cnt <= cnt + 1'b1;
            // Results are published from the final iteration's next values,
            // so they are valid in the same cycle done rises.
            if (last_iter) begin
                quotient    <= q_next;
                remainder   <= r_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_cla_divider.sv
// Self-checking bench for seq_cla_divider: reset, directed vector table,
// hand-written multi-cycle sequences and a randomized sweep against a
// plain-arithmetic reference model.
module tb_seq_cla_divider;

    localparam int W     = 8;
    localparam int LIMIT = W + 6;
    localparam int N_RND = 1500;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_cla_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp_q;
        int exp_r;
        int exp_z;
        int exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: plain integer division with the divide-by-zero rule.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Present start for one edge; returns #1 after that edge.
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Count edges until done is seen, bounded by LIMIT.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit overlap);
        cycles   = 0;
        busy_cnt = 0;
        overlap  = 1'b0;
        while (done !== 1'b1 && cycles < LIMIT) begin
            if (busy === 1'b1) busy_cnt++;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int exp_q,
                         input int exp_r, input int exp_z, input int exp_lat);
        int  cyc;
        int  bcnt;
        bit  ovl;
        start_op(a, b);
        wait_done(cyc, bcnt, ovl);
        check($sformatf("%s_quotient", tag), 32'(quotient), exp_q);
        check($sformatf("%s_remainder", tag), 32'(remainder), exp_r);
        check($sformatf("%s_dbz", tag), 32'(div_by_zero), exp_z);
        check($sformatf("%s_latency", tag), cyc, exp_lat);
        check($sformatf("%s_busy_cycles", tag), bcnt, exp_lat);
        check($sformatf("%s_overlap", tag), 32'(ovl), 0);
        @(posedge clk); #1;
        check($sformatf("%s_done_width", tag), 32'(done), 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   cyc;
        int   bcnt;
        bit   ovl;
        int   lat;
        int   a;
        int   b;
        int   mq;
        int   mr;
        int   mz;

        vecs[0] = '{200,   7,  28,  4, 0, W};
        vecs[1] = '{255,   1, 255,  0, 0, W};
        vecs[2] = '{255, 255,   1,  0, 0, W};
        vecs[3] = '{  5,  10,   0,  5, 0, W};
        vecs[4] = '{ 77,   0, 255, 77, 1, 0};
        vecs[5] = '{  9,   3,   3,  0, 0, W};
        vecs[6] = '{  0,   5,   0,  0, 0, W};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_quotient", 32'(quotient), 0);
        check("reset_remainder", 32'(remainder), 0);
        check("reset_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_q,
                  vecs[i].exp_r, vecs[i].exp_z, vecs[i].exp_lat);
        end

        // Start pulse during RUN is ignored; results still 100/9.
        start_op(100, 9);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ignored_hold_quotient", 32'(quotient), 0);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(cyc, bcnt, ovl);
        lat = cyc + 4;
        check("ignored_latency", lat, W);
        check("ignored_quotient", 32'(quotient), 11);
        check("ignored_remainder", 32'(remainder), 1);
        check("ignored_overlap", 32'(ovl), 0);

        // Back-to-back: start held in the DONE cycle.
        start_op(50, 5);
        check("b2b_done_dropped", 32'(done), 0);
        check("b2b_busy_rose", 32'(busy), 1);
        wait_done(cyc, bcnt, ovl);
        check("b2b_gap", cyc + 1, W + 1);
        check("b2b_quotient", 32'(quotient), 10);
        check("b2b_remainder", 32'(remainder), 0);
        @(posedge clk); #1;
        check("b2b_done_width", 32'(done), 0);

        // Asynchronous reset in the middle of an iteration sequence.
        start_op(200, 7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_dbz", 32'(div_by_zero), 0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle_busy", 32'(busy), 0);
        check("midrst_idle_done", 32'(done), 0);
        do_op("after_rst", 200, 7, 28, 4, 0, W);

        // Randomized sweep against the reference model.
        for (int i = 0; i < N_RND; i++) begin
            a = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
            case ($urandom_range(0, 15))
                0:       b = 0;
                1:       b = 1;
                2:       b = (1 << W) - 1;
                default: b = int'($urandom_range(1, (1 << W) - 1));
            endcase
            ref_div(a, b, mq, mr, mz);
            do_op($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b, mq, mr, mz, (b == 0) ? 0 : W);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
